// File: rtl/c7b_bus_pkg.sv
// c7b_bus_pkg
//   Shared types for the IFU/LSU memory arbiter: requester (owner) encoding
//   and the arbiter FSM state encoding.
package c7b_bus_pkg;

  typedef logic owner_t;
  localparam owner_t OWN_IFU = 1'b0;
  localparam owner_t OWN_LSU = 1'b1;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_REQ  = 1'b1;

endpackage

// File: rtl/c7b_owner_fifo.sv
// c7b_owner_fifo
//   DEPTH-entry, 1-bit-wide in-order FIFO holding the owner of each acked,
//   not-yet-answered bus transaction.
// Ports
//   i_clk, i_reset   clock, async active-high reset
//   i_push, i_din    enqueue owner
//   i_pop            dequeue head (ignored when empty)
//   o_head           owner at the head
//   o_full, o_empty  occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
// A push into an empty FIFO never satisfies a same-cycle pop.
module c7b_owner_fifo
  import c7b_bus_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic   i_clk,
  input  logic   i_reset,
  input  logic   i_push,
  input  owner_t i_din,
  input  logic   i_pop,
  output owner_t o_head,
  output logic   o_full,
  output logic   o_empty
);

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_push, w_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = r_mem[r_rp];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mem <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= nxt(r_wp);
      end
      if (w_pop) r_rp <= nxt(r_rp);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/c7b_mem_arb.sv
// c7b_mem_arb
//   Arbitrates the single memory/ICU bus port between fetch (IFU) and
//   load/store (LSU). Requests are held until ack; responses come back later
//   in order and are routed by an owner FIFO.
// Ports
//   i_clk, i_reset                      clock, async active-high reset
//   i_ifu_req/i_ifu_addr                IFU request, held until o_ifu_ack
//   o_ifu_ack, o_ifu_data_vld           IFU accept / response strobe
//   i_lsu_req/addr/wr/wdata             LSU request, held until o_lsu_ack
//   o_lsu_ack, o_lsu_data_vld           LSU accept / response strobe
//   o_rdata                             shared response data (mem_rdata)
//   o_mem_req/addr/wr/wdata             registered bus request
//   i_mem_ack, i_mem_data_vld, i_mem_rdata  bus handshake / response
//   o_arb_err                           sticky: response with nothing owed
module c7b_mem_arb
  import c7b_bus_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int DEPTH  = 2,
  parameter int STARVE = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ifu_req,
  input  logic [AW-1:0] i_ifu_addr,
  output logic          o_ifu_ack,
  output logic          o_ifu_data_vld,
  input  logic          i_lsu_req,
  input  logic [AW-1:0] i_lsu_addr,
  input  logic          i_lsu_wr,
  input  logic [DW-1:0] i_lsu_wdata,
  output logic          o_lsu_ack,
  output logic          o_lsu_data_vld,
  output logic [DW-1:0] o_rdata,
  output logic          o_mem_req,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_wr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic          i_mem_ack,
  input  logic          i_mem_data_vld,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_arb_err
);

  localparam int SW = $clog2(STARVE + 1);

  state_t        r_state;
  owner_t        r_gnt;
  logic [AW-1:0] r_addr;
  logic          r_wr;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_starve;
  logic          r_err;

  logic   w_push, w_pop, w_room, w_grant, w_ifu_wins;
  logic   w_full, w_empty;
  owner_t w_head;

  c7b_owner_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_din   (r_gnt),
    .i_pop   (i_mem_data_vld),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_push = (r_state == ST_REQ) && i_mem_ack;
  assign w_pop  = i_mem_data_vld && !w_empty;

  // A response retiring this cycle frees a slot, so a full FIFO does not
  // cost an extra idle cycle before the next grant.
  assign w_room     = !w_full || w_pop;
  assign w_grant    = (r_state == ST_IDLE) && (i_ifu_req || i_lsu_req) && w_room;
  assign w_ifu_wins = i_ifu_req && (!i_lsu_req || (r_starve == SW'(STARVE)));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_gnt   <= OWN_IFU;
      r_addr  <= '0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_grant) begin
          r_state <= ST_REQ;
          r_gnt   <= w_ifu_wins ? OWN_IFU : OWN_LSU;
          r_addr  <= w_ifu_wins ? i_ifu_addr : i_lsu_addr;
          r_wr    <= w_ifu_wins ? 1'b0 : i_lsu_wr;
          r_wdata <= w_ifu_wins ? '0 : i_lsu_wdata;
        end
        default: if (i_mem_ack) r_state <= ST_IDLE;
      endcase
    end
  end

  // Counts IDLE grants that IFU loses while requesting; an IFU grant or an
  // idle IFU clears it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_starve <= '0;
    end else if (w_grant) begin
      if (w_ifu_wins || !i_ifu_req) r_starve <= '0;
      else if (r_starve != SW'(STARVE)) r_starve <= r_starve + SW'(1);
    end else if (!i_ifu_req) begin
      r_starve <= '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_err <= 1'b0;
    else if (i_mem_data_vld && w_empty) r_err <= 1'b1;
  end

  assign o_mem_req      = (r_state == ST_REQ);
  assign o_mem_addr     = r_addr;
  assign o_mem_wr       = r_wr;
  assign o_mem_wdata    = r_wdata;
  assign o_ifu_ack      = w_push && (r_gnt == OWN_IFU);
  assign o_lsu_ack      = w_push && (r_gnt == OWN_LSU);
  assign o_ifu_data_vld = w_pop && (w_head == OWN_IFU);
  assign o_lsu_data_vld = w_pop && (w_head == OWN_LSU);
  assign o_rdata        = i_mem_rdata;
  assign o_arb_err      = r_err;

  // The owner must keep requesting until its ack arrives.
  a_ifu_hold: assert property (@(posedge i_clk) disable iff (i_reset)
    (r_state == ST_REQ && r_gnt == OWN_IFU) |-> i_ifu_req);
  a_lsu_hold: assert property (@(posedge i_clk) disable iff (i_reset)
    (r_state == ST_REQ && r_gnt == OWN_LSU) |-> i_lsu_req);

endmodule

// File: tb/tb_c7b_mem_arb.sv
module tb_c7b_mem_arb;
  localparam int DEPTH  = 2;
  localparam int STARVE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ifu_req = 0, lsu_req = 0, lsu_wr = 0, mem_ack = 0, mem_dv = 0;
  logic [31:0] ifu_addr = 0, lsu_addr = 0, lsu_wdata = 0, mem_rdata = 0;
  logic        n_ifu_req = 0, n_lsu_req = 0, n_lsu_wr = 0, n_mem_ack = 0, n_mem_dv = 0;
  logic [31:0] n_ifu_addr = 0, n_lsu_addr = 0, n_lsu_wdata = 0, n_mem_rdata = 0;
  logic        ifu_ack, ifu_dv, lsu_ack, lsu_dv, mem_req, mem_wr, arb_err;
  logic [31:0] rdata, mem_addr, mem_wdata;

  c7b_mem_arb #(.AW(32), .DW(32), .DEPTH(DEPTH), .STARVE(STARVE)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_ifu_req(ifu_req), .i_ifu_addr(ifu_addr), .o_ifu_ack(ifu_ack), .o_ifu_data_vld(ifu_dv),
    .i_lsu_req(lsu_req), .i_lsu_addr(lsu_addr), .i_lsu_wr(lsu_wr), .i_lsu_wdata(lsu_wdata),
    .o_lsu_ack(lsu_ack), .o_lsu_data_vld(lsu_dv), .o_rdata(rdata),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_mem_wr(mem_wr), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_data_vld(mem_dv), .i_mem_rdata(mem_rdata), .o_arb_err(arb_err)
  );

  // Reference model: bus busy flag + payload, owner queue, starve count, error flag.
  bit          m_busy, m_own, m_wr, m_err;
  logic [31:0] m_addr, m_wdata;
  bit          q[$];
  int          m_starve;
  bit c_ifu_ack, c_lsu_ack, c_pop, c_ifu_dv, c_lsu_dv, c_grant, c_win_ifu;
  bit e_ifu_ack, e_lsu_ack;

  int n_vec = 0, n_mis = 0;
  bit auto_req = 0, auto_mem = 0;
  int p_ifu, p_lsu, p_ack, p_dv;

  function void model_comb();
    c_ifu_ack = m_busy && mem_ack && !m_own;
    c_lsu_ack = m_busy && mem_ack && m_own;
    c_pop     = mem_dv && (q.size() > 0);
    c_ifu_dv  = 0;
    c_lsu_dv  = 0;
    if (c_pop) begin
      c_ifu_dv = (q[0] == 0);
      c_lsu_dv = (q[0] == 1);
    end
    c_grant   = !m_busy && (ifu_req || lsu_req) && ((q.size() < DEPTH) || c_pop);
    c_win_ifu = ifu_req && (!lsu_req || m_starve == STARVE);
  endfunction

  function void model_edge();
    model_comb();
    e_ifu_ack = c_ifu_ack;
    e_lsu_ack = c_lsu_ack;
    if (mem_dv && q.size() == 0) m_err = 1;
    if (c_pop) void'(q.pop_front());
    if (m_busy && mem_ack) begin
      q.push_back(m_own);
      m_busy = 0;
    end else if (c_grant) begin
      m_busy  = 1;
      m_own   = !c_win_ifu;
      m_addr  = c_win_ifu ? ifu_addr : lsu_addr;
      m_wr    = c_win_ifu ? 1'b0 : lsu_wr;
      m_wdata = c_win_ifu ? 32'h0 : lsu_wdata;
    end
    if (c_grant) m_starve = c_win_ifu ? 0 : (ifu_req ? ((m_starve < STARVE) ? m_starve + 1 : STARVE) : 0);
    else if (!ifu_req) m_starve = 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("mem_req", mem_req, 32'(m_busy));
    if (m_busy) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wr", mem_wr, 32'(m_wr));
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("ifu_ack", ifu_ack, 32'(c_ifu_ack));
    chk("lsu_ack", lsu_ack, 32'(c_lsu_ack));
    chk("ifu_data_vld", ifu_dv, 32'(c_ifu_dv));
    chk("lsu_data_vld", lsu_dv, 32'(c_lsu_dv));
    chk("arb_err", arb_err, 32'(m_err));
    if (c_ifu_dv || c_lsu_dv) chk("rdata", rdata, mem_rdata);
  endtask

  task automatic apply();
    ifu_req = n_ifu_req; ifu_addr = n_ifu_addr;
    lsu_req = n_lsu_req; lsu_addr = n_lsu_addr; lsu_wr = n_lsu_wr; lsu_wdata = n_lsu_wdata;
    mem_ack = n_mem_ack; mem_dv = n_mem_dv; mem_rdata = n_mem_rdata;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    if (auto_req) begin
      if (!(ifu_req && !e_ifu_ack)) begin
        n_ifu_req  = ($urandom_range(99) < p_ifu);
        n_ifu_addr = $urandom;
      end
      if (!(lsu_req && !e_lsu_ack)) begin
        n_lsu_req   = ($urandom_range(99) < p_lsu);
        n_lsu_addr  = $urandom;
        n_lsu_wr    = $urandom_range(1);
        n_lsu_wdata = $urandom;
      end
    end
    if (auto_mem) begin
      n_mem_ack   = m_busy && ($urandom_range(99) < p_ack);
      n_mem_dv    = (q.size() > 0) && ($urandom_range(99) < p_dv);
      n_mem_rdata = $urandom;
    end
    #1;
    apply();
    model_comb();
    @(negedge clk);
    compare();
  endtask

  // Asynchronous reset applied wherever the bench currently is (mid-cycle).
  task automatic do_reset();
    rst = 1;
    auto_req = 0; auto_mem = 0;
    n_ifu_req = 0; n_ifu_addr = 0; n_lsu_req = 0; n_lsu_addr = 0; n_lsu_wr = 0;
    n_lsu_wdata = 0; n_mem_ack = 0; n_mem_dv = 0; n_mem_rdata = 0;
    apply();
    m_busy = 0; m_own = 0; m_wr = 0; m_err = 0; m_addr = 0; m_wdata = 0;
    m_starve = 0; q.delete();
    model_comb();
    #2;
    compare();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_arb_err", arb_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nl;
    bit got;

    do_reset();

    // 1) Single IFU read
    n_ifu_req = 1; n_ifu_addr = 32'h1C00_0000; step();
    chk("t1_no_req_yet", mem_req, 0);
    step();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h1C00_0000);
    chk("t1_mem_wr", mem_wr, 0);
    step();
    chk("t1_no_early_ack", ifu_ack, 0);
    n_mem_ack = 1; step();
    chk("t1_ifu_ack", ifu_ack, 1);
    n_mem_ack = 0; n_ifu_req = 0; step();
    chk("t1_req_drop", mem_req, 0);
    step(); step();
    n_mem_dv = 1; n_mem_rdata = 32'hDEAD_BEEF; step();
    chk("t1_ifu_dv", ifu_dv, 1);
    chk("t1_rdata", rdata, 32'hDEAD_BEEF);
    chk("t1_lsu_dv", lsu_dv, 0);
    n_mem_dv = 0; step();

    // 2) Simultaneous requests: LSU first, responses in order
    n_ifu_req = 1; n_ifu_addr = 32'hA000_0000;
    n_lsu_req = 1; n_lsu_addr = 32'hB000_0000; n_lsu_wr = 0; n_lsu_wdata = 32'h5;
    step(); step();
    chk("t2_first_addr", mem_addr, 32'hB000_0000);
    n_mem_ack = 1; step();
    chk("t2_lsu_ack", lsu_ack, 1);
    chk("t2_ifu_no_ack", ifu_ack, 0);
    n_mem_ack = 0; n_lsu_req = 0; step(); step();
    chk("t2_second_addr", mem_addr, 32'hA000_0000);
    n_mem_ack = 1; step();
    chk("t2_ifu_ack", ifu_ack, 1);
    n_mem_ack = 0; n_ifu_req = 0; n_mem_dv = 1; n_mem_rdata = 32'h1111; step();
    chk("t2_lsu_dv_first", lsu_dv, 1);
    n_mem_rdata = 32'h2222; step();
    chk("t2_ifu_dv_second", ifu_dv, 1);
    n_mem_dv = 0; step();

    // 3) Starvation: IFU gets in after exactly STARVE LSU wins, twice in a row
    do_reset();
    n_lsu_req = 1; n_lsu_addr = 32'h40; n_lsu_wr = 1; n_lsu_wdata = 32'h77;
    n_ifu_req = 1; n_ifu_addr = 32'h80;
    auto_mem = 1; p_ack = 100; p_dv = 100;
    for (int r = 0; r < 2; r++) begin
      nl = 0; got = 0;
      for (int k = 0; k < 40 && !got; k++) begin
        step();
        if (lsu_ack) nl++;
        if (ifu_ack) got = 1;
      end
      chk("t3_ifu_granted", 32'(got), 1);
      chk("t3_lsu_wins", nl, STARVE);
    end

    // 4) FIFO full stalls the next grant until a response frees a slot
    do_reset();
    n_ifu_req = 1; n_ifu_addr = 32'h100; step(); step();
    n_mem_ack = 1; step();
    n_mem_ack = 0; n_ifu_addr = 32'h104; step(); step();
    chk("t4_second_req", mem_req, 1);
    n_mem_ack = 1; step();
    chk("t4_second_ack", ifu_ack, 1);
    n_mem_ack = 0; n_ifu_addr = 32'h108; step();
    chk("t4_full_a", mem_req, 0);
    step(); chk("t4_full_b", mem_req, 0);
    step(); chk("t4_full_c", mem_req, 0);
    n_mem_dv = 1; n_mem_rdata = 32'h3333; step();
    chk("t4_free_dv", ifu_dv, 1);
    chk("t4_free_no_req", mem_req, 0);
    n_mem_dv = 0; step();
    chk("t4_req_after_free", mem_req, 1);
    chk("t4_addr_after_free", mem_addr, 32'h108);
    n_mem_ack = 1; step();
    n_mem_ack = 0; n_ifu_req = 0; n_mem_dv = 1; step(); step();
    n_mem_dv = 0; step();

    // 5) Same-cycle ack + data_vld with one outstanding
    do_reset();
    n_lsu_req = 1; n_lsu_addr = 32'h200; n_lsu_wr = 1; n_lsu_wdata = 32'hCAFE; step(); step();
    chk("t5_lsu_wr", mem_wr, 1);
    chk("t5_lsu_wdata", mem_wdata, 32'hCAFE);
    n_mem_ack = 1; step();
    chk("t5_lsu_ack", lsu_ack, 1);
    n_mem_ack = 0; n_lsu_req = 0; n_ifu_req = 1; n_ifu_addr = 32'h300; step(); step();
    chk("t5_ifu_wr0", mem_wr, 0);
    chk("t5_ifu_wdata0", mem_wdata, 0);
    n_mem_ack = 1; n_mem_dv = 1; n_mem_rdata = 32'h4444; step();
    chk("t5_ifu_ack", ifu_ack, 1);
    chk("t5_lsu_dv", lsu_dv, 1);
    chk("t5_no_ifu_dv", ifu_dv, 0);
    n_mem_ack = 0; n_ifu_req = 0; n_mem_dv = 0; step();
    n_mem_dv = 1; n_mem_rdata = 32'h5555; step();
    chk("t5_ifu_dv", ifu_dv, 1);
    chk("t5_rdata", rdata, 32'h5555);
    n_mem_dv = 0; step();

    // 6) Stray response, push+pop on empty, reset during REQ
    do_reset();
    n_mem_dv = 1; step();
    chk("t6_stray_no_ifu_dv", ifu_dv, 0);
    chk("t6_stray_no_lsu_dv", lsu_dv, 0);
    n_mem_dv = 0; step();
    chk("t6_arb_err", arb_err, 1);
    n_ifu_req = 1; n_ifu_addr = 32'h600; step(); step();
    n_mem_ack = 1; n_mem_dv = 1; step();
    chk("t6_empty_pp_ack", ifu_ack, 1);
    chk("t6_empty_pp_no_dv", ifu_dv, 0);
    n_mem_ack = 0; n_mem_dv = 0; n_ifu_req = 0; step();
    n_mem_dv = 1; n_mem_rdata = 32'h6666; step();
    chk("t6_pushed_entry_dv", ifu_dv, 1);
    n_mem_dv = 0; n_ifu_req = 1; n_ifu_addr = 32'h700; step(); step();
    chk("t6_in_req", mem_req, 1);
    do_reset();
    n_mem_dv = 1; step();
    chk("t6_post_rst_no_dv", ifu_dv, 0);
    n_mem_dv = 0; step();
    chk("t6_post_rst_err", arb_err, 1);

    // Randomized traffic against the model
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      auto_req = 1; auto_mem = 1;
      case (ph)
        0: begin p_ifu = 50; p_lsu = 50; p_ack = 50; p_dv = 50; end
        1: begin p_ifu = 90; p_lsu = 90; p_ack = 80; p_dv = 20; end
        2: begin p_ifu = 95; p_lsu = 95; p_ack = 100; p_dv = 100; end
        default: begin p_ifu = 30; p_lsu = 70; p_ack = 30; p_dv = 70; end
      endcase
      repeat (800) step();
    end
    auto_req = 0; auto_mem = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
